efuse_trim_loader: RTL and testbench

//  Consumes the eFuse controller's autoload stream: NR-bit words with vld strobes, terminated by a done pulse.

---
 rtl/efuse_pkg.sv | 30 +++
 rtl/efuse_trim_chksum.sv | 22 ++
 rtl/efuse_trim_loader.sv | 207 ++++++++++++++++++++
 tb/tb_efuse_trim_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// -----------------------------------------------------------------------------
// efuse_pkg
// Shared types and helpers for the eFuse trim loader.
//   trim_st_e     : loader FSM states
//   EFUSE_BITS    : width of the trim shadow image
//   efuse_chksum  : mod-256 sum of bytes 0..30 of an image
// -----------------------------------------------------------------------------
package efuse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } trim_st_e;

  localparam int EFUSE_BITS = 256;

  // Byte-wise mod-256 sum of the lower 31 bytes; byte 31 carries the expected value.
  function automatic logic [7:0] efuse_chksum(input logic [247:0] img);
    logic [7:0] sum_v;
    sum_v = 8'h00;
    for (int i = 0; i < 31; i++) begin
      sum_v = sum_v + img[i*8 +: 8];
    end
    return sum_v;
  endfunction

endpackage

// File: rtl/efuse_trim_chksum.sv
// -----------------------------------------------------------------------------
// efuse_trim_chksum
// Combinational checksum compare for the trim image: byte 31 must equal the
// mod-256 sum of bytes 0..30.
// Only compiled when EFUSE_TRIM_CHKSUM_EN is defined; without the macro the
// file is empty and no checksum hardware exists.
// Ports:
//   img  in  256  shadow image to check
//   ok   out 1    1 when byte 31 matches the computed sum
// -----------------------------------------------------------------------------
`ifdef EFUSE_TRIM_CHKSUM_EN
module efuse_trim_chksum
  import efuse_pkg::*;
(
  input  logic [EFUSE_BITS-1:0] img,
  output logic                  ok
);

  assign ok = (img[255:248] == efuse_chksum(img[247:0]));

endmodule
`endif

// File: rtl/efuse_trim_loader.sv
// -----------------------------------------------------------------------------
// efuse_trim_loader
// Captures the eFuse autoload word stream into a 256-bit shadow image, checks
// word count (and optionally a checksum), and publishes the trim image plus
// status flags to the trim consumers. A start pulse restarts the load from
// any state.
//
// Build option: EFUSE_TRIM_CHKSUM_EN -- when defined, byte 31 of the image
// must equal the mod-256 sum of bytes 0..30 for the image to be valid.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pmu_efuse_start       pulse, (re)start a load
//   efuse_autoload_vld    pulse, efuse_autoload_data holds the next word
//   efuse_autoload_data   NR-bit autoload word, ascending word order
//   efuse_autoload_done   pulse, autoload finished
//   rg_trim_ovr_en/_data  register override of the published image
//   trim_data_o           registered active trim image
//   trim_valid/err/timeout/blank   mutually exclusive status levels
//   loader_busy           high while loading or checking
// -----------------------------------------------------------------------------
module efuse_trim_loader
  import efuse_pkg::*;
#(
  parameter int                    NR          = 64,
  parameter int                    TIMEOUT_CYC = 16383,
  parameter logic [EFUSE_BITS-1:0] DEF_TRIM    = 256'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmu_efuse_start,
  input  logic                  efuse_autoload_vld,
  input  logic [NR-1:0]         efuse_autoload_data,
  input  logic                  efuse_autoload_done,
  input  logic                  rg_trim_ovr_en,
  input  logic [EFUSE_BITS-1:0] rg_trim_ovr_data,
  output logic [EFUSE_BITS-1:0] trim_data_o,
  output logic                  trim_valid,
  output logic                  trim_err,
  output logic                  trim_timeout,
  output logic                  trim_blank,
  output logic                  loader_busy
);

  localparam int NW  = EFUSE_BITS / NR;
  localparam int WCW = $clog2(NW + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] NW_L  = WCW'(NW);
  localparam logic [TCW-1:0] TMO_L = TCW'(TIMEOUT_CYC);

  trim_st_e              state_r,    state_s;
  logic [WCW-1:0]        word_cnt_r, word_cnt_s;
  logic [TCW-1:0]        tmo_cnt_r,  tmo_cnt_s;
  logic [EFUSE_BITS-1:0] shadow_r,   shadow_s;
  logic                  overrun_r,  overrun_s;
  logic                  valid_r,    valid_s;
  logic                  err_r,      err_s;
  logic                  timeout_r,  timeout_s;
  logic                  blank_r,    blank_s;
  logic                  busy_r,     busy_s;
  logic [EFUSE_BITS-1:0] trim_data_r, trim_data_s;
  logic                  chk_ok_s;

`ifdef EFUSE_TRIM_CHKSUM_EN
  efuse_trim_chksum u_chksum (
    .img (shadow_r),
    .ok  (chk_ok_s)
  );
`else
  assign chk_ok_s = 1'b1;
`endif

  // Next-state, capture and flag decision logic.
  always_comb begin
    state_s    = state_r;
    word_cnt_s = word_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    shadow_s   = shadow_r;
    overrun_s  = overrun_r;
    valid_s    = valid_r;
    err_s      = err_r;
    timeout_s  = timeout_r;
    blank_s    = blank_r;

    if (pmu_efuse_start) begin
      // Start wins over everything: a mid-load start discards the partial image.
      state_s    = LOAD;
      word_cnt_s = {WCW{1'b0}};
      tmo_cnt_s  = {TCW{1'b0}};
      shadow_s   = {EFUSE_BITS{1'b0}};
      overrun_s  = 1'b0;
      valid_s    = 1'b0;
      err_s      = 1'b0;
      timeout_s  = 1'b0;
      blank_s    = 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (efuse_autoload_vld) begin
            if (word_cnt_r == NW_L) begin
              // Count saturates; the extra word is dropped and remembered.
              overrun_s = 1'b1;
            end else begin
              for (int i = 0; i < NW; i++) begin
                if (word_cnt_r == WCW'(i)) begin
                  shadow_s[i*NR +: NR] = efuse_autoload_data;
                end else begin
                  shadow_s[i*NR +: NR] = shadow_r[i*NR +: NR];
                end
              end
              word_cnt_s = word_cnt_r + WCW'(1);
            end
          end else begin
            overrun_s = overrun_r;
          end

          // A word arriving with done is captured above before CHECK counts it.
          if (efuse_autoload_done) begin
            state_s = CHECK;
          end else if (tmo_cnt_r == TMO_L) begin
            state_s   = ERR;
            timeout_s = 1'b1;
          end else begin
            tmo_cnt_s = tmo_cnt_r + TCW'(1);
          end
        end

        CHECK: begin
          if ((word_cnt_r != NW_L) || overrun_r) begin
            state_s = ERR;
            err_s   = 1'b1;
          end else if (shadow_r == {EFUSE_BITS{1'b0}}) begin
            state_s = DONE;
            blank_s = 1'b1;
          end else if (chk_ok_s) begin
            state_s = DONE;
            valid_s = 1'b1;
          end else begin
            state_s = ERR;
            err_s   = 1'b1;
          end
        end

        IDLE, DONE, ERR: begin
          state_s = state_r;
        end

        default: begin
          // Illegal encoding: fall back to a safe, flag-free idle.
          state_s   = IDLE;
          valid_s   = 1'b0;
          err_s     = 1'b0;
          timeout_s = 1'b0;
          blank_s   = 1'b0;
        end
      endcase
    end

    busy_s = (state_s == LOAD) || (state_s == CHECK);

    // Published image follows the flag that becomes visible on the same edge.
    if (rg_trim_ovr_en) begin
      trim_data_s = rg_trim_ovr_data;
    end else if (valid_s) begin
      trim_data_s = shadow_s;
    end else begin
      trim_data_s = DEF_TRIM;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      word_cnt_r  <= {WCW{1'b0}};
      tmo_cnt_r   <= {TCW{1'b0}};
      shadow_r    <= {EFUSE_BITS{1'b0}};
      overrun_r   <= 1'b0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      timeout_r   <= 1'b0;
      blank_r     <= 1'b0;
      busy_r      <= 1'b0;
      trim_data_r <= DEF_TRIM;
    end else begin
      state_r     <= state_s;
      word_cnt_r  <= word_cnt_s;
      tmo_cnt_r   <= tmo_cnt_s;
      shadow_r    <= shadow_s;
      overrun_r   <= overrun_s;
      valid_r     <= valid_s;
      err_r       <= err_s;
      timeout_r   <= timeout_s;
      blank_r     <= blank_s;
      busy_r      <= busy_s;
      trim_data_r <= trim_data_s;
    end
  end

  assign trim_data_o  = trim_data_r;
  assign trim_valid   = valid_r;
  assign trim_err     = err_r;
  assign trim_timeout = timeout_r;
  assign trim_blank   = blank_r;
  assign loader_busy  = busy_r;

endmodule

// File: tb/tb_efuse_trim_loader.sv
// -----------------------------------------------------------------------------
// tb_efuse_trim_loader
// Directed bench for efuse_trim_loader (NR = 64, TIMEOUT_CYC = 100, non-zero
// DEF_TRIM so fallbacks are visible). A transaction-level model tracks which
// words were delivered and derives the expected flags and image from the
// load rules; a negedge process compares every output each cycle, and literal
// checks pin the model at key points. Honours EFUSE_TRIM_CHKSUM_EN.
// -----------------------------------------------------------------------------
module tb_efuse_trim_loader;

  localparam int NR  = 64;
  localparam int NW  = 4;
  localparam int TMO = 100;
  localparam logic [255:0] DEF_T = {32{8'h3C}};
  localparam logic [255:0] OVR_T = {32{8'hA5}};
  localparam logic [255:0] IMG1  = {8'h1F, {31{8'h01}}};
  localparam logic [255:0] IMG2  = {8'h20, {31{8'h01}}};
  localparam logic [255:0] IMG3  = {8'h3E, {31{8'h02}}};
`ifdef EFUSE_TRIM_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          vld = 1'b0;
  logic          done = 1'b0;
  logic [63:0]   data = 64'h0;
  logic          ovr_en = 1'b0;
  logic [255:0]  ovr_data = OVR_T;
  logic [255:0]  trim_data_o;
  logic          trim_valid, trim_err, trim_timeout, trim_blank, loader_busy;

  int n_chk = 0;
  int n_err = 0;

  // Model state
  bit           chk_en = 1'b0;
  logic         m_valid = 1'b0, m_err = 1'b0, m_tmo = 1'b0, m_blank = 1'b0, m_busy = 1'b0;
  logic [255:0] m_image = 256'h0;
  logic [255:0] m_acc = 256'h0;
  int           m_cnt = 0;
  logic         ovr_q;

  efuse_trim_loader #(
    .NR          (NR),
    .TIMEOUT_CYC (TMO),
    .DEF_TRIM    (DEF_T)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pmu_efuse_start     (start),
    .efuse_autoload_vld  (vld),
    .efuse_autoload_data (data),
    .efuse_autoload_done (done),
    .rg_trim_ovr_en      (ovr_en),
    .rg_trim_ovr_data    (ovr_data),
    .trim_data_o         (trim_data_o),
    .trim_valid          (trim_valid),
    .trim_err            (trim_err),
    .trim_timeout        (trim_timeout),
    .trim_blank          (trim_blank),
    .loader_busy         (loader_busy)
  );

  always #5 clk = ~clk;

  // Override as seen by the output register at the last edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_en;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bytesum(input logic [255:0] img);
    logic [7:0] s;
    s = 8'h00;
    for (int b = 0; b < 31; b++) s = s + img[b*8 +: 8];
    return s;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",   {255'b0, trim_valid},   {255'b0, m_valid});
      check("err",     {255'b0, trim_err},     {255'b0, m_err});
      check("timeout", {255'b0, trim_timeout}, {255'b0, m_tmo});
      check("blank",   {255'b0, trim_blank},   {255'b0, m_blank});
      check("busy",    {255'b0, loader_busy},  {255'b0, m_busy});
      check("data", trim_data_o, ovr_q ? OVR_T : (m_valid ? m_image : DEF_T));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_err = 1'b0; m_tmo = 1'b0; m_blank = 1'b0; m_busy = 1'b0;
    m_cnt = 0; m_acc = 256'h0;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    m_busy = 1'b1;
  endtask

  // One check cycle after done, then the verdict is visible.
  task automatic finish_load();
    tick();
    m_busy = 1'b0;
    if (m_cnt != NW) m_err = 1'b1;
    else if (m_acc == 256'h0) m_blank = 1'b1;
    else if (CHK_ON && (m_acc[255:248] != bytesum(m_acc))) m_err = 1'b1;
    else begin
      m_valid = 1'b1;
      m_image = m_acc;
    end
  endtask

  task automatic send_word(input logic [63:0] w, input bit last);
    vld = 1'b1; data = w; done = last;
    tick();
    vld = 1'b0; done = 1'b0;
    if (m_cnt < NW) m_acc[m_cnt*NR +: NR] = w;
    m_cnt++;
    if (last) finish_load();
  endtask

  task automatic send_done();
    done = 1'b1;
    tick();
    done = 1'b0;
    finish_load();
  endtask

  task automatic load_image(input logic [255:0] img, input int nwords, input bit merge_done);
    for (int i = 0; i < nwords; i++) begin
      send_word(img[(i % NW)*64 +: 64] ^ ((i >= NW) ? 64'hDEAD_BEEF_0000_0000 : 64'h0),
                merge_done && (i == nwords - 1));
    end
    if (!merge_done) send_done();
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_data",  trim_data_o, DEF_T);
    check("rst_flags", {252'b0, trim_valid, trim_err, trim_timeout, trim_blank}, 256'h0);
    check("rst_busy",  {255'b0, loader_busy}, 256'h0);
    rst_n = 1'b1;
    model_clear();
    chk_en = 1'b1;
    repeat (2) tick();

    // 1: normal load
    start_load();
    load_image(IMG1, NW, 1'b0);
    check("t1_valid", {255'b0, trim_valid}, 256'h1);
    check("t1_data",  trim_data_o, IMG1);
    check("t1_busy",  {255'b0, loader_busy}, 256'h0);

    // 2: bad checksum byte
    start_load();
    load_image(IMG2, NW, 1'b0);
`ifdef EFUSE_TRIM_CHKSUM_EN
    check("t2_err",  {255'b0, trim_err}, 256'h1);
    check("t2_data", trim_data_o, DEF_T);
`else
    check("t2_valid", {255'b0, trim_valid}, 256'h1);
    check("t2_data",  trim_data_o, IMG2);
`endif

    // 3: short and long loads
    start_load();
    load_image(IMG1, 3, 1'b0);
    check("t3_short_err", {255'b0, trim_err}, 256'h1);
    start_load();
    load_image(IMG1, 5, 1'b0);
    check("t3_long_err",  {255'b0, trim_err}, 256'h1);
    check("t3_long_data", trim_data_o, DEF_T);

    // 4: timeout, late done/vld ignored
    start_load();
    repeat (TMO) tick();
    check("t4_pre_tmo",  {255'b0, trim_timeout}, 256'h0);
    check("t4_pre_busy", {255'b0, loader_busy}, 256'h1);
    tick();
    m_busy = 1'b0;
    m_tmo  = 1'b1;
    check("t4_tmo", {255'b0, trim_timeout}, 256'h1);
    vld = 1'b1; done = 1'b1; data = 64'h1234;
    tick();
    vld = 1'b0; done = 1'b0;
    tick();
    check("t4_late_done", {254'b0, trim_timeout, trim_valid}, 256'h2);

    // 5a: restart mid-load
    start_load();
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    start_load();
    load_image(IMG3, NW, 1'b0);
    check("t5_restart_valid", {255'b0, trim_valid}, 256'h1);
    check("t5_restart_data",  trim_data_o, IMG3);

    // 5b: vld together with done on the last word
    start_load();
    load_image(IMG1, NW, 1'b1);
    check("t5_merge_valid", {255'b0, trim_valid}, 256'h1);
    check("t5_merge_data",  trim_data_o, IMG1);

    // 5c: blank image
    start_load();
    load_image(256'h0, NW, 1'b0);
    check("t5_blank", {254'b0, trim_blank, trim_valid}, 256'h2);

    // 6: override in DONE, LOAD, DONE; release returns to shadow
    ovr_en = 1'b1;
    tick();
    check("t6_ovr_done_blank", trim_data_o, OVR_T);
    start_load();
    send_word(IMG1[63:0], 1'b0);
    send_word(IMG1[127:64], 1'b0);
    check("t6_ovr_load", trim_data_o, OVR_T);
    send_word(IMG1[191:128], 1'b0);
    send_word(IMG1[255:192], 1'b1);
    check("t6_ovr_done", trim_data_o, OVR_T);
    ovr_en = 1'b0;
    tick();
    check("t6_release", trim_data_o, IMG1);

    // Async reset mid-load
    start_load();
    send_word(IMG1[63:0], 1'b0);
    send_word(IMG1[127:64], 1'b0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("ar_data",  trim_data_o, DEF_T);
    check("ar_flags", {251'b0, trim_valid, trim_err, trim_timeout, trim_blank, loader_busy}, 256'h0);
    tick();
    rst_n = 1'b1;
    model_clear();
    chk_en = 1'b1;
    tick();

    // Override in IDLE, then release to default
    ovr_en = 1'b1;
    tick();
    check("t6_ovr_idle", trim_data_o, OVR_T);
    ovr_en = 1'b0;
    tick();
    check("t6_idle_release", trim_data_o, DEF_T);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
